fault_sweep_ctrl: RTL
=====================

Name: fault_sweep_ctrl

Overview:
Sequencer for serial single-stuck-at fault grading of a small combinational gate netlist, such as the cmpgt cell. For each fault index, it drives an exhaustive input-pattern sweep into a fault-free copy and a fault-injected copy of the gate. It compares the two outputs, stops at the first mismatching pattern and reports each fault result over a valid/ready handshake. It also accumulates a detected-fault count and sits between the gate copies and the result logger.

Parameters:
PAT_W, 2, width of the gate input pattern ({a,b} for cmpgt)
NUM_FLT, 8, number of enumerated faults; indices 0..NUM_FLT-1
FLT_W, 3, width of the fault index; must satisfy 2**FLT_W >= NUM_FLT

Ports:
clk  input  1  single clock; all state changes on rising edge
rst_n  input  1  asynchronous, active-low reset
start  input  1  pulse; begins a sweep when in IDLE or DONE
abort  input  1  synchronous; returns to IDLE from any state
good_resp  input  1  output of the fault-free gate copy for the current pat_out
fault_resp  input  1  output of the fault-injected gate copy for the current pat_out
det_ready  input  1  result consumer accepts det_* this cycle
pat_out  output  PAT_W  registered pattern driven to both gate copies
flt_sel  output  FLT_W  registered index of the fault currently injected
flt_en  output  1  fault injection enable; the faulty copy behaves as good when 0
busy  output  1  high in APPLY or REPORT
det_valid  output  1  result available
det_fault  output  FLT_W  fault index of the result
det_hit  output  1  1 = detected, 0 = undetected after the full sweep
det_pattern  output  PAT_W  first detecting pattern; all-ones if undetected
coverage  output  FLT_W+1  count of detected faults in the current or last sweep
done  output  1  sweep complete; held until next start or abort

Behaviour:
- Reset (rst_n=0, async): state=IDLE, and every output is 0: pat_out, flt_sel, flt_en, busy, det_valid, det_fault, det_hit, det_pattern, coverage, done.
- States: IDLE, APPLY, REPORT, DONE.
- IDLE/DONE with start=1: pat_out=0, flt_sel=0, flt_en=1, coverage=0, done=0, then go to APPLY. start is ignored in APPLY/REPORT.
- Gate copies are combinational. good_resp and fault_resp are evaluated in the same cycle pat_out/flt_sel are stable; no extra pipeline stage.
- APPLY, each cycle:
  - If good_resp != fault_resp: latch det_hit=1 and det_pattern=pat_out, then go to REPORT.
  - Else if pat_out == all-ones: det_hit=0, det_pattern=all-ones, then go to REPORT.
  - Else pat_out <= pat_out+1.
  - Latency per fault is (first detecting pattern + 1) APPLY cycles, or 2**PAT_W if undetected.
- REPORT: det_valid=1 and det_fault=flt_sel. det_* stay stable until det_ready=1.
  - On the accepting edge: det_valid=0, and coverage increments if det_hit=1 (saturating at NUM_FLT).
  - If flt_sel == NUM_FLT-1: go to DONE (flt_en=0, done=1).
  - Else flt_sel+1, pat_out=0, then go to APPLY.
  - With det_ready held 1, REPORT lasts exactly 1 cycle.
- DONE: busy=0 and done=1. coverage and the last det_* values hold; pat_out holds its last value.
- abort=1 in any state (sampled at edge): go to IDLE; flt_en, busy, det_valid and done go to 0; coverage holds. abort takes priority over start and over det_ready in the same cycle.
- Async reset mid-sweep: immediate return to the reset state; no partial result is emitted.
- pat_out wrap never occurs: the all-ones check precedes the increment.

Test Plan:
- cmpgt gate (o = b & ~a), pattern {a,b}, faults 0..7 = a/0, a/1, b/0, b/1, n/0, n/1, o/0, o/1 (n = ~a net), det_ready=1, start pulse -> results (fault:pattern) = 0:11, 1:01, 2:01, 3:00, 4:01, 5:11, 6:01, 7:00, all det_hit=1.
  - Required: coverage=8, and done rises exactly 26 cycles after the start-accept edge (18 APPLY + 8 REPORT).
- Undetectable fault (bench forces fault_resp=good_resp for fault 2) -> 4 APPLY cycles, det_hit=0, det_pattern=2'b11, coverage=7.
- det_ready low for 3 cycles during the fault 0 REPORT -> det_valid and det_* stable for 4 cycles, pat_out/flt_sel frozen, coverage increments once.
- abort asserted in APPLY of fault 4 -> next cycle IDLE, flt_en=0, busy=0, done=0, coverage=4.
  - A following start restarts from flt_sel=0 with coverage=0.
- rst_n pulsed low mid-REPORT (asynchronous, between edges) -> det_valid and all outputs 0 immediately. start during APPLY is ignored.
- start in DONE -> new sweep; done drops on the next edge and the results repeat identically.

Source files
------------

// File: rtl/fault_sweep_if.sv
// Handshake and gate-copy bundle between the fault sweep sequencer and its environment.
// master = sequencer side, slave = gate copies / result logger side.
interface fault_sweep_if #(
    parameter int PAT_W = 2,
    parameter int FLT_W = 3
);
    logic             start;
    logic             abort;
    logic             good_resp;
    logic             fault_resp;
    logic             det_ready;
    logic [PAT_W-1:0] pat_out;
    logic [FLT_W-1:0] flt_sel;
    logic             flt_en;
    logic             busy;
    logic             det_valid;
    logic [FLT_W-1:0] det_fault;
    logic             det_hit;
    logic [PAT_W-1:0] det_pattern;
    logic [FLT_W:0]   coverage;
    logic             done;

    modport master (
        input  start, abort, good_resp, fault_resp, det_ready,
        output pat_out, flt_sel, flt_en, busy, det_valid, det_fault,
               det_hit, det_pattern, coverage, done
    );

    modport slave (
        output start, abort, good_resp, fault_resp, det_ready,
        input  pat_out, flt_sel, flt_en, busy, det_valid, det_fault,
               det_hit, det_pattern, coverage, done
    );
endinterface

// File: rtl/fault_sweep_ctrl.sv
// Serial single-stuck-at fault grading sequencer: sweeps every input pattern per fault,
// stops at the first good/faulty mismatch and reports each result over valid/ready.
//
// state  | meaning
// IDLE   | waiting for start; no fault injected
// APPLY  | one pattern per cycle into both gate copies, comparing responses
// REPORT | det_* presented, waiting for det_ready
// DONE   | all faults graded; coverage and last result held
module fault_sweep_ctrl #(
    parameter int PAT_W   = 2,
    parameter int NUM_FLT = 8,
    parameter int FLT_W   = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    fault_sweep_if.master bus
);
    typedef enum logic [1:0] {IDLE, APPLY, REPORT, DONE} state_t;

    localparam logic [FLT_W-1:0] LAST_FLT = FLT_W'(NUM_FLT - 1);
    localparam logic [FLT_W:0]   COV_MAX  = (FLT_W + 1)'(NUM_FLT);

    state_t           stateQ, stateD;
    logic [PAT_W-1:0] patQ;
    logic [FLT_W-1:0] fltQ;
    logic             fltEnQ;
    logic [FLT_W-1:0] detFaultQ;
    logic             detHitQ;
    logic [PAT_W-1:0] detPatternQ;
    logic [FLT_W:0]   coverageQ;

    logic mismatch;
    logic patLast;
    logic fltLast;
    logic busyC;
    logic doneC;
    logic detValidC;

    assign mismatch = bus.good_resp != bus.fault_resp;
    assign patLast  = patQ == {PAT_W{1'b1}};
    assign fltLast  = fltQ == LAST_FLT;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateQ <= IDLE;
        end else begin
            stateQ <= stateD;
        end
    end

    always_comb begin
        stateD = stateQ;
        if (bus.abort) begin
            stateD = IDLE;
        end else begin
            case (stateQ)
                IDLE, DONE: if (bus.start) stateD = APPLY;
                APPLY:      if (mismatch || patLast) stateD = REPORT;
                REPORT:     if (bus.det_ready) stateD = fltLast ? DONE : APPLY;
                default:    stateD = IDLE;
            endcase
        end
    end

    always_comb begin
        busyC     = (stateQ == APPLY) || (stateQ == REPORT);
        doneC     = stateQ == DONE;
        detValidC = stateQ == REPORT;
    end

    // The all-ones check comes before the increment, so pat_out never wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            patQ        <= '0;
            fltQ        <= '0;
            fltEnQ      <= 1'b0;
            detFaultQ   <= '0;
            detHitQ     <= 1'b0;
            detPatternQ <= '0;
            coverageQ   <= '0;
        end else if (bus.abort) begin
            fltEnQ <= 1'b0;
        end else begin
            case (stateQ)
                IDLE, DONE: begin
                    if (bus.start) begin
                        patQ      <= '0;
                        fltQ      <= '0;
                        fltEnQ    <= 1'b1;
                        coverageQ <= '0;
                    end
                end
                APPLY: begin
                    if (mismatch) begin
                        detHitQ     <= 1'b1;
                        detPatternQ <= patQ;
                        detFaultQ   <= fltQ;
                    end else if (patLast) begin
                        detHitQ     <= 1'b0;
                        detPatternQ <= {PAT_W{1'b1}};
                        detFaultQ   <= fltQ;
                    end else begin
                        patQ <= patQ + 1'b1;
                    end
                end
                REPORT: begin
                    if (bus.det_ready) begin
                        if (detHitQ && (coverageQ != COV_MAX)) begin
                            coverageQ <= coverageQ + 1'b1;
                        end
                        if (fltLast) begin
                            fltEnQ <= 1'b0;
                        end else begin
                            fltQ <= fltQ + 1'b1;
                            patQ <= '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.pat_out     = patQ;
    assign bus.flt_sel     = fltQ;
    assign bus.flt_en      = fltEnQ;
    assign bus.busy        = busyC;
    assign bus.det_valid   = detValidC;
    assign bus.det_fault   = detFaultQ;
    assign bus.det_hit     = detHitQ;
    assign bus.det_pattern = detPatternQ;
    assign bus.coverage    = coverageQ;
    assign bus.done        = doneC;
endmodule
